block_compare: RTL and testbench

BLOCK_COMPARE -- requirements
Module: block_compare

---
 rtl/block_compare_pkg.sv | 49 ++++
 rtl/block_compare_probe_addr.sv | 34 +++
 rtl/block_compare.sv | 131 +++++++++++++
 tb/tb_block_compare.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/block_compare_pkg.sv
// Shared game constants: tile types, tile geometry, arena defaults and the
// probe-point offset table used by the collision checker.
package block_compare_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    PILLAR = 2'd1,
    SOFT   = 2'd2,
    BOMB   = 2'd3
  } tile_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PROBE  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int TILE_SIZE    = 16;
  localparam int ARENA_X0_DEF = 144;
  localparam int ARENA_Y0_DEF = 16;
  localparam int COLS_DEF     = 21;
  localparam int ROWS_DEF     = 25;

  // Offsets are 11-bit two's complement so that -1 wraps far outside the arena.
  function automatic logic [10:0] probe_dx(input logic [2:0] k);
    logic [10:0] d;
    d = '0;
    case (k)
      3'd0, 3'd1: d = '1;
      3'd2, 3'd3: d = 11'(TILE_SIZE);
      3'd5, 3'd7: d = 11'(TILE_SIZE - 1);
      default:    d = '0;
    endcase
    return d;
  endfunction

  function automatic logic [10:0] probe_dy(input logic [2:0] k);
    logic [10:0] d;
    d = '0;
    case (k)
      3'd1, 3'd3: d = 11'(TILE_SIZE - 1);
      3'd4, 3'd5: d = '1;
      3'd6, 3'd7: d = 11'(TILE_SIZE);
      default:    d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/block_compare_probe_addr.sv
// Combinational pixel-to-tile mapping: (x, y) -> in-arena flag and linear
// tile index row*COLS+col (forced to zero outside the arena).
module probe_addr
  import block_compare_pkg::*;
#(
  parameter int ARENA_X0 = ARENA_X0_DEF,
  parameter int ARENA_Y0 = ARENA_Y0_DEF,
  parameter int COLS     = COLS_DEF,
  parameter int ROWS     = ROWS_DEF
) (
  input  logic [10:0] i_x,
  input  logic [10:0] i_y,
  output logic        o_in_arena,
  output logic [9:0]  o_addr
);

  logic [10:0] w_dx;
  logic [10:0] w_dy;
  logic [6:0]  w_col;
  logic [6:0]  w_row;
  logic [9:0]  w_lin;

  always_comb begin
    w_dx  = i_x - 11'(ARENA_X0);
    w_dy  = i_y - 11'(ARENA_Y0);
    w_col = 7'(w_dx >> 4);
    w_row = 7'(w_dy >> 4);
    w_lin = 10'(w_row) * 10'(COLS) + 10'(w_col);
    o_in_arena = (i_x >= 11'(ARENA_X0)) && (i_x < 11'(ARENA_X0 + TILE_SIZE * COLS)) &&
                 (i_y >= 11'(ARENA_Y0)) && (i_y < 11'(ARENA_Y0 + TILE_SIZE * ROWS));
    o_addr = o_in_arena ? w_lin : '0;
  end

endmodule

// File: rtl/block_compare.sv
// Sprite collision checker: probes eight tile-map points around the sprite
// and reports per-direction blocked flags {left, right, up, down}.
module block_compare
  import block_compare_pkg::*;
#(
  parameter int ARENA_X0 = ARENA_X0_DEF,
  parameter int ARENA_Y0 = ARENA_Y0_DEF,
  parameter int COLS     = COLS_DEF,
  parameter int ROWS     = ROWS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] b_x,
  input  logic [9:0] b_y,
  output logic       map_rd,
  output logic [9:0] map_addr,
  input  logic [1:0] map_data,
  output logic [3:0] bomberman_blocked,
  output logic       done
);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [9:0]  r_bx;
  logic [9:0]  r_by;
  logic [7:0]  r_hit;
  logic        r_rd_d1;
  logic        r_map_rd;
  logic [9:0]  r_map_addr;
  logic [3:0]  r_blocked;
  logic        r_done;

  logic        w_accept;
  logic        w_issue;
  logic [2:0]  w_k;
  logic [9:0]  w_src_x;
  logic [9:0]  w_src_y;
  logic [10:0] w_px;
  logic [10:0] w_py;
  logic        w_in;
  logic [9:0]  w_addr;
  logic        w_tile_hit;

  // Probe k0 is issued on the accepting edge itself, so it reads the live inputs.
  always_comb begin
    w_accept   = (r_state == IDLE) && start;
    w_src_x    = (r_state == IDLE) ? b_x : r_bx;
    w_src_y    = (r_state == IDLE) ? b_y : r_by;
    w_k        = (r_state == IDLE) ? 3'd0 : r_cnt[2:0];
    w_px       = {1'b0, w_src_x} + probe_dx(w_k);
    w_py       = {1'b0, w_src_y} + probe_dy(w_k);
    w_issue    = w_accept || ((r_state == PROBE) && (r_cnt <= 4'd7));
    w_tile_hit = !r_rd_d1 || (map_data != 2'(EMPTY));
  end

  probe_addr #(
    .ARENA_X0 (ARENA_X0),
    .ARENA_Y0 (ARENA_Y0),
    .COLS     (COLS),
    .ROWS     (ROWS)
  ) u_probe (
    .i_x        (w_px),
    .i_y        (w_py),
    .o_in_arena (w_in),
    .o_addr     (w_addr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = PROBE;
      PROBE:   if (r_cnt == 4'd9) w_next = COMMIT;
      COMMIT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // r_rd_d1 remembers whether the probe whose data arrives now was in-arena.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_bx       <= '0;
      r_by       <= '0;
      r_hit      <= '0;
      r_rd_d1    <= 1'b0;
      r_map_rd   <= 1'b0;
      r_map_addr <= '0;
      r_blocked  <= '1;
      r_done     <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_rd_d1    <= r_map_rd;
      r_map_rd   <= w_issue && w_in;
      r_map_addr <= (w_issue && w_in) ? w_addr : '0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_bx  <= b_x;
            r_by  <= b_y;
            r_cnt <= 4'd1;
            r_hit <= '0;
          end
        end
        PROBE: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt >= 4'd2) r_hit[3'(r_cnt - 4'd2)] <= w_tile_hit;
        end
        COMMIT: begin
          r_blocked <= {r_hit[0] | r_hit[1], r_hit[2] | r_hit[3],
                        r_hit[4] | r_hit[5], r_hit[6] | r_hit[7]};
          r_done    <= 1'b1;
          r_cnt     <= '0;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign map_rd            = r_map_rd;
  assign map_addr          = r_map_addr;
  assign bomberman_blocked = r_blocked;
  assign done              = r_done;

endmodule

// File: tb/tb_block_compare.sv
// Directed bench for block_compare with a registered tile-map RAM model.
module tb_block_compare;
  import block_compare_pkg::*;

  logic       clk;
  logic       reset;
  logic       start;
  logic [9:0] b_x;
  logic [9:0] b_y;
  logic       map_rd;
  logic [9:0] map_addr;
  logic [1:0] map_data;
  logic [3:0] bomberman_blocked;
  logic       done;

  logic [1:0] mem [0:1023];
  logic       rd_log   [0:9];
  logic [9:0] addr_log [0:9];
  int total;
  int bad;
  int done_seen;
  logic rd_any;

  block_compare #(
    .ARENA_X0 (144),
    .ARENA_Y0 (16),
    .COLS     (21),
    .ROWS     (25)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .b_x               (b_x),
    .b_y               (b_y),
    .map_rd            (map_rd),
    .map_addr          (map_addr),
    .map_data          (map_data),
    .bomberman_blocked (bomberman_blocked),
    .done              (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (map_rd) map_data <= mem[map_addr];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_map();
    for (int i = 0; i < 1024; i++) mem[i] = 2'(EMPTY);
  endtask

  task automatic eval(input logic [9:0] bx, input logic [9:0] by,
                      input logic [3:0] exp, input string tag);
    @(negedge clk);
    b_x = bx; b_y = by; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rd_log[0] = map_rd; addr_log[0] = map_addr;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      rd_log[k] = map_rd; addr_log[k] = map_addr;
      if (k == 9) chk({tag, "_done_early"}, done, 0);
    end
    @(posedge clk); #1;
    chk({tag, "_done_e10"}, done, 1);
    chk({tag, "_blocked"}, bomberman_blocked, exp);
    @(posedge clk); #1;
    chk({tag, "_done_e11"}, done, 0);
    chk({tag, "_hold"}, bomberman_blocked, exp);
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; start = 1'b0; b_x = '0; b_y = '0;
    clear_map();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_blocked", bomberman_blocked, 4'b1111);
    chk("rst_done", done, 0);
    chk("rst_rd", map_rd, 0);
    chk("rst_addr", map_addr, 0);
    @(negedge clk); reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_done", done, 0);

    // all-empty map at bottom-left corner of the arena
    eval(10'd144, 10'd400, 4'b1001, "empty");
    chk("empty_k0_rd", rd_log[0], 0);
    chk("empty_k0_addr", addr_log[0], 0);
    chk("empty_k2_rd", rd_log[2], 1);
    chk("empty_k2_addr", addr_log[2], 505);
    chk("empty_k4_addr", addr_log[4], 483);
    chk("empty_k6_rd", rd_log[6], 0);
    chk("empty_e8_rd", rd_log[8], 0);

    mem[505] = 2'(PILLAR);
    eval(10'd144, 10'd400, 4'b1101, "pillar505");
    chk("pillar505_k2_addr", addr_log[2], 505);

    clear_map();
    mem[253] = 2'(PILLAR);
    eval(10'd150, 10'd200, 4'b0101, "pillar253");
    chk("pillar253_k3_addr", addr_log[3], 253);
    chk("pillar253_k7_addr", addr_log[7], 253);

    // reset in the middle of probing
    @(negedge clk);
    b_x = 10'd150; b_y = 10'd200; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_e5_rd", map_rd, 1);
    chk("mid_e5_addr", map_addr, 232);
    reset = 1'b1;
    #1;
    chk("mid_rst_blocked", bomberman_blocked, 4'b1111);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_rd", map_rd, 0);
    chk("mid_rst_addr", map_addr, 0);
    @(negedge clk); reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    chk("mid_no_done", 16'(done_seen), 0);
    chk("mid_hold", bomberman_blocked, 4'b1111);

    // sprite at origin: every probe lies outside the arena
    eval(10'd0, 10'd0, 4'b1111, "origin");
    rd_any = 1'b0;
    for (int k = 0; k <= 9; k++) rd_any = rd_any | rd_log[k];
    chk("origin_no_rd", rd_any, 0);

    // start held high; position changes mid-probe only affect the next pass
    clear_map();
    @(negedge clk);
    b_x = 10'd144; b_y = 10'd400; start = 1'b1;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    b_x = 10'd0; b_y = 10'd0;
    repeat (7) @(posedge clk);
    #1;
    chk("held_done_e10", done, 1);
    chk("held_blocked1", bomberman_blocked, 4'b1001);
    @(posedge clk); #1;
    chk("held_done_e11", done, 0);
    repeat (9) @(posedge clk);
    #1;
    chk("held_done_e20", done, 0);
    @(posedge clk); #1;
    chk("held_done_e21", done, 1);
    chk("held_blocked2", bomberman_blocked, 4'b1111);
    start = 1'b0;
    @(posedge clk); #1;
    chk("held_done_e22", done, 0);
    repeat (12) @(posedge clk);
    #1;
    chk("held_idle_done", done, 0);
    chk("held_idle_rd", map_rd, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
